rf_plus_alu: RTL and testbench

Register-file-plus-ALU datapath slice of the multicycle 16-bit RISC. It holds eight 16-bit general registers and an ID/EXE pipeline buffer (instruction latch plus two operand latches), and feeds a 16-bit add/subtract ALU. The controller sequences it through decode, execute and writeback using single-bit control strobes. The PSW register itself lives outside this block.

---
 rtl/rf_plus_alu.sv | 115 +++++++++++
 tb/tb_rf_plus_alu.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/rf_plus_alu.sv
// rf_plus_alu: register-file-plus-ALU datapath slice of the multicycle 16-bit RISC.
// Eight 16-bit general registers, an ID/EXE buffer (instruction latch plus two
// operand latches) and a 16-bit add/subtract ALU with load-immediate bypass.
//
// Optional feature macro: RF_R0_ZERO_EN -- when defined, R0 reads as zero and
// writes to R0 are dropped.
//
// Ports:
//   clk         clock, all state updates on rising edge
//   Reset       synchronous active-high reset, clears RF and ID/EXE buffer
//   Ins         instruction from IF latch ([10:8] Rd, [7:5] Rm, [7:0] imm8, [4:0] imm5)
//   Buff_IDEXE  load IL_EXE / operand A / operand B
//   RBresource  read-port-B address select (0: Ins[7:5], 1: Ins[10:8])
//   OprandB     ALU B source (0: operand-B latch, 1: sign-extended IL_EXE[4:0])
//   LI          load immediate: Sum = zero-extended IL_EXE[7:0], C = 0
//   ALUop       0 add, 1 subtract
//   Flag        use PSW_C as carry-in
//   PSW_C       carry bit from PSW
//   WBRF        register-file write enable
//   WBresource  write data select (0: WBData, 1: Sum)
//   WBData      external writeback data
//   IL_EXE      latched instruction in EXE
//   OutR        operand-A latch
//   Sum, C, Z   combinational ALU result, carry-out, zero flag
//   Rd, Rm      one-hot decodes of IL_EXE[10:8] and IL_EXE[7:5]
module rf_plus_alu (
  input  logic        clk,
  input  logic        Reset,
  input  logic [15:0] Ins,
  input  logic        Buff_IDEXE,
  input  logic        RBresource,
  input  logic        OprandB,
  input  logic        LI,
  input  logic        ALUop,
  input  logic        Flag,
  input  logic        PSW_C,
  input  logic        WBRF,
  input  logic        WBresource,
  input  logic [15:0] WBData,
  output logic [15:0] IL_EXE,
  output logic [15:0] OutR,
  output logic [15:0] Sum,
  output logic        C,
  output logic        Z,
  output logic [7:0]  Rd,
  output logic [7:0]  Rm
);

  logic [15:0] regs [8];
  logic [15:0] opb;
  logic [2:0]  addr_a, addr_b, wr_addr;
  logic [15:0] port_a, port_b, wr_data;
  logic        wr_en;
  logic [15:0] bin, bin_eff;
  logic        cin;
  logic [16:0] alu_full;

  always_comb begin
    addr_a  = Ins[10:8];
    addr_b  = RBresource ? Ins[10:8] : Ins[7:5];
    port_a  = regs[addr_a];
    port_b  = regs[addr_b];
    wr_addr = IL_EXE[10:8];
    wr_data = WBresource ? Sum : WBData;
    wr_en   = WBRF;
`ifdef RF_R0_ZERO_EN
    if (addr_a == '0) port_a = '0;
    if (addr_b == '0) port_b = '0;
    if (wr_addr == '0) wr_en = 1'b0;
`endif
  end

  // Write address comes from IL_EXE as it stands before this edge, and the
  // operand latches capture pre-write array contents (no bypass).
  always_ff @(posedge clk) begin
    if (Reset) begin
      regs   <= '{default: '0};
      IL_EXE <= '0;
      OutR   <= '0;
      opb    <= '0;
    end else begin
      if (Buff_IDEXE) begin
        IL_EXE <= Ins;
        OutR   <= port_a;
        opb    <= port_b;
      end
      if (wr_en) regs[wr_addr] <= wr_data;
    end
  end

  // Subtract is A + ~B + cin; with cin = 1 this is two's-complement A - B and
  // C = 1 means no borrow.
  always_comb begin
    bin      = OprandB ? {{11{IL_EXE[4]}}, IL_EXE[4:0]} : opb;
    cin      = Flag ? PSW_C : ALUop;
    bin_eff  = ALUop ? ~bin : bin;
    alu_full = {1'b0, OutR} + {1'b0, bin_eff} + {16'b0, cin};
    if (LI) begin
      Sum = {8'h00, IL_EXE[7:0]};
      C   = 1'b0;
    end else begin
      Sum = alu_full[15:0];
      C   = alu_full[16];
    end
    Z = (Sum == 16'h0000);
  end

  always_comb begin
    Rd = '0;
    Rm = '0;
    Rd[IL_EXE[10:8]] = 1'b1;
    Rm[IL_EXE[7:5]]  = 1'b1;
  end

endmodule

// File: tb/tb_rf_plus_alu.sv
module tb_rf_plus_alu;

  logic        clk = 1'b0;
  logic        Reset = 1'b0;
  logic [15:0] Ins = '0;
  logic        Buff_IDEXE = 1'b0, RBresource = 1'b0, OprandB = 1'b0, LI = 1'b0;
  logic        ALUop = 1'b0, Flag = 1'b0, PSW_C = 1'b0, WBRF = 1'b0, WBresource = 1'b0;
  logic [15:0] WBData = '0;
  logic [15:0] IL_EXE, OutR, Sum;
  logic        C, Z;
  logic [7:0]  Rd, Rm;

  int checks = 0;
  int failures = 0;
  logic [15:0] exp_q [$];

  rf_plus_alu dut (
    .clk(clk), .Reset(Reset), .Ins(Ins), .Buff_IDEXE(Buff_IDEXE),
    .RBresource(RBresource), .OprandB(OprandB), .LI(LI), .ALUop(ALUop),
    .Flag(Flag), .PSW_C(PSW_C), .WBRF(WBRF), .WBresource(WBresource),
    .WBData(WBData), .IL_EXE(IL_EXE), .OutR(OutR), .Sum(Sum), .C(C), .Z(Z),
    .Rd(Rd), .Rm(Rm)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [15:0] obs);
    logic [15:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $error("FAIL %s observed=%h expected=<empty scoreboard>", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, e);
      end
    end
  endtask

  function automatic logic [15:0] mk_ins(input logic [2:0] rd, input logic [2:0] rm,
                                         input logic [4:0] imm5);
    return {5'b0, rd, rm, imm5};
  endfunction

  task automatic load(input logic [15:0] ins);
    Ins = ins;
    Buff_IDEXE = 1'b1;
    tick();
    Buff_IDEXE = 1'b0;
  endtask

  task automatic setreg(input logic [2:0] r, input logic [15:0] v);
    load(mk_ins(r, 3'd0, 5'd0));
    WBRF = 1'b1;
    WBresource = 1'b0;
    WBData = v;
    tick();
    WBRF = 1'b0;
  endtask

  initial begin
    // reset state
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    #1;
    push(16'h0000); check("rst_il_exe", IL_EXE);
    push(16'h0000); check("rst_outr", OutR);
    push(16'h0001); check("rst_rd", {8'h00, Rd});
    push(16'h0001); check("rst_rm", {8'h00, Rm});
    push(16'h0000); check("rst_sum", Sum);
    push(16'h0000); check("rst_c", {15'b0, C});
    push(16'h0001); check("rst_z", {15'b0, Z});

    // external writeback then read-back through operand A
    setreg(3'd3, 16'h1234);
    push(16'h1234);
    load(mk_ins(3'd3, 3'd0, 5'd0));
    check("wb_read_r3", OutR);
    push(16'h0008); check("rd_onehot_3", {8'h00, Rd});

    // ADD wrap: FFFF + 0001
    setreg(3'd1, 16'hFFFF);
    setreg(3'd2, 16'h0001);
    load(mk_ins(3'd1, 3'd2, 5'd0));
    ALUop = 1'b0;
    #1;
    push(16'h0000); check("add_sum", Sum);
    push(16'h0001); check("add_c", {15'b0, C});
    push(16'h0001); check("add_z", {15'b0, Z});
    push(16'h0004); check("rm_onehot_2", {8'h00, Rm});
    WBRF = 1'b1; WBresource = 1'b1;
    tick();
    WBRF = 1'b0; WBresource = 1'b0;
    push(16'h0000);
    load(mk_ins(3'd1, 3'd0, 5'd0));
    check("add_wb_r1", OutR);

    // SUB 5 - 7, then with PSW_C carry-in
    setreg(3'd1, 16'h0005);
    setreg(3'd2, 16'h0007);
    load(mk_ins(3'd1, 3'd2, 5'd0));
    ALUop = 1'b1;
    #1;
    push(16'hFFFE); check("sub_sum", Sum);
    push(16'h0000); check("sub_c", {15'b0, C});
    push(16'h0000); check("sub_z", {15'b0, Z});
    Flag = 1'b1; PSW_C = 1'b0;
    #1;
    push(16'hFFFD); check("sbc_sum", Sum);
    Flag = 1'b0; ALUop = 1'b0;

    // read-port-B select: rd=2 (7), rm=3 (1234)
    load(mk_ins(3'd2, 3'd3, 5'd0));
    push(16'h123B); check("rb_rm_sum", Sum);
    RBresource = 1'b1;
    load(mk_ins(3'd2, 3'd3, 5'd0));
    RBresource = 1'b0;
    push(16'h000E); check("rb_rd_sum", Sum);

    // sign-extended imm5
    setreg(3'd1, 16'h0010);
    load(mk_ins(3'd1, 3'd0, 5'b11111));
    OprandB = 1'b1;
    #1;
    push(16'h000F); check("imm5_sum", Sum);
    push(16'h0001); check("imm5_c", {15'b0, C});
    OprandB = 1'b0;

    // load immediate, written to R0
    load({5'b0, 3'd0, 8'hA5});
    LI = 1'b1;
    ALUop = 1'b1;
    #1;
    push(16'h00A5); check("li_sum", Sum);
    push(16'h0000); check("li_c", {15'b0, C});
    push(16'h0000); check("li_z", {15'b0, Z});
    WBRF = 1'b1; WBresource = 1'b1;
    tick();
    WBRF = 1'b0; WBresource = 1'b0; LI = 1'b0; ALUop = 1'b0;
`ifdef RF_R0_ZERO_EN
    push(16'h0000);
`else
    push(16'h00A5);
`endif
    load(mk_ins(3'd0, 3'd0, 5'd0));
    check("r0_read", OutR);

    // same-edge write and load to reg4: latch sees old value
    load(mk_ins(3'd4, 3'd0, 5'd0));
    WBRF = 1'b1; WBresource = 1'b0; WBData = 16'hBEEF;
    push(16'h0000);
    load(mk_ins(3'd4, 3'd0, 5'd0));
    WBRF = 1'b0;
    check("no_bypass", OutR);
    push(16'hBEEF);
    load(mk_ins(3'd4, 3'd0, 5'd0));
    check("after_write_r4", OutR);

    // reset beats write; reg5 stays 0
    load(mk_ins(3'd5, 3'd0, 5'd0));
    WBRF = 1'b1; WBData = 16'h1111; Reset = 1'b1;
    tick();
    WBRF = 1'b0; Reset = 1'b0;
    push(16'h0000); check("rst_clr_il", IL_EXE);
    push(16'h0000);
    load(mk_ins(3'd5, 3'd0, 5'd0));
    check("rst_no_write_r5", OutR);
    push(16'h0000);
    load(mk_ins(3'd4, 3'd0, 5'd0));
    check("rst_clr_r4", OutR);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
